// File: rtl/uart_bus_master_pkg.sv
// Shared frame/response byte constants and the controller state encoding
// for the UART debug bus master.
package uart_bus_master_pkg;

  localparam logic [7:0] CMD_READ    = 8'h52;
  localparam logic [7:0] CMD_WRITE   = 8'h57;
  localparam logic [7:0] RSP_OK      = 8'h4B;
  localparam logic [7:0] RSP_ERR     = 8'h3F;
  localparam logic [7:0] RSP_TIMEOUT = 8'h54;
  localparam logic [2:0] FIELD_LAST  = 3'd3;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ADDR = 3'd1,
    S_DATA = 3'd2,
    S_REQ  = 3'd3,
    S_BUS  = 3'd4,
    S_TX   = 3'd5,
    S_TXW  = 3'd6
  } state_e;

endpackage

// File: rtl/uart_bus_master_txq.sv
// Response buffer and transmit sequencer: sends len_i bytes of a 32-bit word,
// LSB first, issuing each start only while the transmitter is idle.
module uart_bus_master_txq
  import uart_bus_master_pkg::*;
(
  input  logic        clkMain,
  input  logic        rst,
  input  logic        load_i,
  input  logic [2:0]  len_i,
  input  logic [31:0] data_i,
  input  logic        txdBusy_i,
  output logic        txdStart_o,
  output logic [7:0]  txdData_o,
  output logic        busy_o
);

  state_e      state_q, state_d;
  logic [31:0] rsp_q, rsp_d;
  logic [2:0]  len_q, len_d;
  logic [2:0]  idx_q, idx_d;
  logic        settle_q, settle_d;
  logic        start_q, start_d;
  logic [7:0]  data_q, data_d;

  // Next-state and output logic for the TX/TXW handshake.
  always_comb begin
    state_d  = state_q;
    rsp_d    = rsp_q;
    len_d    = len_q;
    idx_d    = idx_q;
    settle_d = settle_q;
    start_d  = 1'b0;
    data_d   = data_q;
    case (state_q)
      S_IDLE: begin
        if (load_i) begin
          rsp_d   = data_i;
          len_d   = len_i;
          idx_d   = 3'd0;
          state_d = S_TX;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_TX: begin
        if (!txdBusy_i) begin
          start_d  = 1'b1;
          data_d   = rsp_q[{idx_q[1:0], 3'b000} +: 8];
          settle_d = 1'b1;
          state_d  = S_TXW;
        end else begin
          state_d = S_TX;
        end
      end
      S_TXW: begin
        // Busy rises only after the transmitter has seen our start pulse.
        if (settle_q) begin
          settle_d = 1'b0;
        end else if (!txdBusy_i) begin
          idx_d = idx_q + 3'd1;
          if (idx_d == len_q) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_TX;
          end
        end else begin
          state_d = S_TXW;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Sequencer registers.
  always_ff @(posedge clkMain) begin
    if (rst) begin
      state_q  <= S_IDLE;
      rsp_q    <= 32'd0;
      len_q    <= 3'd0;
      idx_q    <= 3'd0;
      settle_q <= 1'b0;
      start_q  <= 1'b0;
      data_q   <= 8'd0;
    end else begin
      state_q  <= state_d;
      rsp_q    <= rsp_d;
      len_q    <= len_d;
      idx_q    <= idx_d;
      settle_q <= settle_d;
      start_q  <= start_d;
      data_q   <= data_d;
    end
  end

  assign txdStart_o = start_q;
  assign txdData_o  = data_q;
  assign busy_o     = (state_q != S_IDLE);

endmodule

// File: rtl/uart_bus_master.sv
// UART-driven debug bus initiator: parses R/W command frames and issues single
// 32-bit device bus transactions. Optional inter-byte timeout: UART_BUS_MASTER_TIMEOUT_EN.
module uart_bus_master
  import uart_bus_master_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 32'd25000000,
  parameter logic [3:0]  BYTE_SEL       = 4'b1111
) (
  input  logic        clkMain,
  input  logic        rst,
  input  logic        rxdReady_i,
  input  logic [7:0]  rxdData_i,
  input  logic        txdBusy_i,
  output logic        txdStart_o,
  output logic [7:0]  txdData_o,
  output logic        busReq_o,
  input  logic        busGnt_i,
  output logic        devEnable_o,
  output logic        devWrite_o,
  input  logic        devBusy_i,
  output logic [31:0] devDataSave_o,
  input  logic [31:0] devDataLoad_i,
  output logic [31:0] devPhysicalAddr_o,
  output logic [3:0]  devByteSelect_o,
  output logic        active_o
);

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        write_q, write_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        bus_req_q, bus_req_d;
  logic        dev_enable_q, dev_enable_d;
  logic [3:0]  byte_sel_q, byte_sel_d;
  logic        active_q, active_d;
  logic        rsp_load_s;
  logic [2:0]  rsp_len_s;
  logic [31:0] rsp_data_s;
  logic        txq_busy_s;
  logic        in_frame_s;
  logic        timeout_s;

  assign in_frame_s = (state_q == S_ADDR) || (state_q == S_DATA);

`ifdef UART_BUS_MASTER_TIMEOUT_EN
  logic [24:0] gap_q, gap_d;

  // Inter-byte gap counter, running only while a frame is being collected.
  always_comb begin
    if (rxdReady_i || !in_frame_s) begin
      gap_d = 25'd0;
    end else begin
      gap_d = gap_q + 25'd1;
    end
  end

  // Gap counter register.
  always_ff @(posedge clkMain) begin
    if (rst) begin
      gap_q <= 25'd0;
    end else begin
      gap_q <= gap_d;
    end
  end

  assign timeout_s = in_frame_s && (gap_q == 25'(TIMEOUT_CYCLES - 32'd1));
`else
  logic [31:0] timeout_unused_s;
  assign timeout_unused_s = TIMEOUT_CYCLES;
  assign timeout_s        = 1'b0;
`endif

  // Frame parser and bus transaction sequencer.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    write_d    = write_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rsp_load_s = 1'b0;
    rsp_len_s  = 3'd0;
    rsp_data_s = 32'd0;
    case (state_q)
      S_IDLE: begin
        if (rxdReady_i) begin
          if ((rxdData_i == CMD_READ) || (rxdData_i == CMD_WRITE)) begin
            write_d = (rxdData_i == CMD_WRITE);
            cnt_d   = 3'd0;
            state_d = S_ADDR;
          end else begin
            rsp_load_s = 1'b1;
            rsp_len_s  = 3'd1;
            rsp_data_s = {24'd0, RSP_ERR};
            state_d    = S_TX;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ADDR: begin
        if (rxdReady_i) begin
          addr_d[{cnt_q[1:0], 3'b000} +: 8] = rxdData_i;
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == FIELD_LAST) begin
            cnt_d   = 3'd0;
            state_d = write_q ? S_DATA : S_REQ;
          end else begin
            state_d = S_ADDR;
          end
        end else if (timeout_s) begin
          rsp_load_s = 1'b1;
          rsp_len_s  = 3'd1;
          rsp_data_s = {24'd0, RSP_TIMEOUT};
          state_d    = S_TX;
        end else begin
          state_d = S_ADDR;
        end
      end
      S_DATA: begin
        if (rxdReady_i) begin
          wdata_d[{cnt_q[1:0], 3'b000} +: 8] = rxdData_i;
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == FIELD_LAST) begin
            state_d = S_REQ;
          end else begin
            state_d = S_DATA;
          end
        end else if (timeout_s) begin
          rsp_load_s = 1'b1;
          rsp_len_s  = 3'd1;
          rsp_data_s = {24'd0, RSP_TIMEOUT};
          state_d    = S_TX;
        end else begin
          state_d = S_DATA;
        end
      end
      S_REQ: begin
        if (busGnt_i) begin
          state_d = S_BUS;
        end else begin
          state_d = S_REQ;
        end
      end
      S_BUS: begin
        // Completion ignores busGnt_i: a granted transaction always runs to the end.
        if (dev_enable_q && !devBusy_i) begin
          rsp_load_s = 1'b1;
          if (write_q) begin
            rsp_len_s  = 3'd1;
            rsp_data_s = {24'd0, RSP_OK};
          end else begin
            rsp_len_s  = 3'd4;
            rsp_data_s = devDataLoad_i;
          end
          state_d = S_TX;
        end else begin
          state_d = S_BUS;
        end
      end
      S_TX: begin
        if (!txq_busy_s) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_TX;
        end
      end
      default: state_d = S_IDLE;
    endcase

    bus_req_d    = (state_d == S_REQ) || (state_d == S_BUS);
    dev_enable_d = (state_d == S_BUS);
    byte_sel_d   = dev_enable_d ? BYTE_SEL : 4'b0000;
    active_d     = (state_d != S_IDLE);
  end

  // Controller state and registered bus outputs.
  always_ff @(posedge clkMain) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= 3'd0;
      write_q      <= 1'b0;
      addr_q       <= 32'd0;
      wdata_q      <= 32'd0;
      bus_req_q    <= 1'b0;
      dev_enable_q <= 1'b0;
      byte_sel_q   <= 4'b0000;
      active_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      write_q      <= write_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      bus_req_q    <= bus_req_d;
      dev_enable_q <= dev_enable_d;
      byte_sel_q   <= byte_sel_d;
      active_q     <= active_d;
    end
  end

  uart_bus_master_txq u_txq (
    .clkMain    (clkMain),
    .rst        (rst),
    .load_i     (rsp_load_s),
    .len_i      (rsp_len_s),
    .data_i     (rsp_data_s),
    .txdBusy_i  (txdBusy_i),
    .txdStart_o (txdStart_o),
    .txdData_o  (txdData_o),
    .busy_o     (txq_busy_s)
  );

  assign busReq_o          = bus_req_q;
  assign devEnable_o       = dev_enable_q;
  assign devWrite_o        = write_q;
  assign devDataSave_o     = wdata_q;
  assign devPhysicalAddr_o = addr_q;
  assign devByteSelect_o   = byte_sel_q;
  assign active_o          = active_q;

endmodule
